// File: rtl/elevator_scheduler.sv
// SCAN-policy car controller for a 4-floor elevator: latches requests, steps the
// car one floor per travel interval and holds the door open at serviced floors.
module elevator_scheduler #(
  parameter int unsigned TRAVEL_CYCLES = 100000000,
  parameter int unsigned DOOR_CYCLES   = 150000000,
  parameter int unsigned CNT_W         = 28
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn,
  output logic [3:0] pending,
  output logic [1:0] floor,
  output logic       moving_up,
  output logic       moving_down,
  output logic       door_open,
  output logic       dir_up,
  output logic       arrive
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MOVE_UP,
    S_MOVE_DOWN,
    S_DOOR_OPEN
  } state_t;

  localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOOR_LAST   = CNT_W'(DOOR_CYCLES - 1);

  state_t           state_q, state_d;
  logic [1:0]       floor_q, floor_d;
  logic [3:0]       pending_q, pending_d;
  logic             dir_up_q, dir_up_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             arrive_q, arrive_d;

  logic             going_up;
  logic [1:0]       floor_step;
  logic [3:0]       above, below, ahead;
  logic [3:0]       set_mask, clr_mask;

  assign going_up   = (state_q == S_MOVE_UP);
  assign floor_step = going_up ? floor_q + 2'd1 : floor_q - 2'd1;

  // ahead[] is relative to the floor the car is about to reach, not the current one
  for (genvar gi = 0; gi < 4; gi++) begin : g_masks
    assign above[gi] = pending_q[gi] && (2'(gi) > floor_q);
    assign below[gi] = pending_q[gi] && (2'(gi) < floor_q);
    assign ahead[gi] = pending_q[gi] &&
                       (going_up ? (2'(gi) > floor_step) : (2'(gi) < floor_step));
  end

  always_comb begin
    state_d  = state_q;
    floor_d  = floor_q;
    dir_up_d = dir_up_q;
    timer_d  = timer_q;
    arrive_d = 1'b0;
    clr_mask = 4'b0000;
    set_mask = btn;
    if (state_q == S_IDLE || state_q == S_DOOR_OPEN) begin
      set_mask[floor_q] = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (btn[floor_q]) begin
          state_d  = S_DOOR_OPEN;
          arrive_d = 1'b1;
        end else if (dir_up_q && (|above)) begin
          state_d = S_MOVE_UP;
        end else if (|below) begin
          state_d  = S_MOVE_DOWN;
          dir_up_d = 1'b0;
        end else if (|above) begin
          state_d  = S_MOVE_UP;
          dir_up_d = 1'b1;
        end
      end

      S_MOVE_UP, S_MOVE_DOWN: begin
        if (timer_q == TRAVEL_LAST) begin
          timer_d = '0;
          floor_d = floor_step;
          // A press landing on the arrival floor in the same cycle also stops the car
          if (pending_q[floor_step] || btn[floor_step]) begin
            clr_mask[floor_step] = 1'b1;
            arrive_d             = 1'b1;
            state_d              = S_DOOR_OPEN;
          end else if (!(|ahead)) begin
            state_d = S_IDLE;
          end
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end

      S_DOOR_OPEN: begin
        if (btn[floor_q]) begin
          timer_d = '0;
        end else if (timer_q == DOOR_LAST) begin
          timer_d = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    pending_d = (pending_q | set_mask) & ~clr_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      floor_q   <= 2'd0;
      pending_q <= 4'b0000;
      dir_up_q  <= 1'b1;
      timer_q   <= '0;
      arrive_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      pending_q <= pending_d;
      dir_up_q  <= dir_up_d;
      timer_q   <= timer_d;
      arrive_q  <= arrive_d;
    end
  end

  assign pending     = pending_q;
  assign floor       = floor_q;
  assign moving_up   = (state_q == S_MOVE_UP);
  assign moving_down = (state_q == S_MOVE_DOWN);
  assign door_open   = (state_q == S_DOOR_OPEN);
  assign dir_up      = dir_up_q;
  assign arrive      = arrive_q;

endmodule
